// File: rtl/hist_pass_sequencer_pkg.sv
// Shared types for the histogram two-pass sequencer.
// State encoding and the fixed image-memory read latency.
package hist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PASS1,
    DRAIN1,
    PASS2,
    DRAIN2
  } state_e;

  localparam int RD_LAT = 1;

endpackage

// File: rtl/hist_pass_sequencer_if.sv
// Control/status bundle between the sequencer, the image memory,
// the histogram bank and the output writer.
interface hist_pass_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int BIN_AW = 8
);

  logic              start;
  logic              abort;
  logic              rd_en;
  logic [ADDR_W-1:0] pix_addr;
  logic              hist_clr;
  logic [BIN_AW-1:0] clr_addr;
  logic              acc_en;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic              enable;
  logic              busy;
  logic              done;
  logic              reallydone;

  modport master (
    output start, abort,
    input  rd_en, pix_addr, hist_clr,
    input  clr_addr, acc_en, we, wr_addr,
    input  enable, busy, done, reallydone
  );

  modport slave (
    input  start, abort,
    output rd_en, pix_addr, hist_clr,
    output clr_addr, acc_en, we, wr_addr,
    output enable, busy, done, reallydone
  );

endinterface

// File: rtl/hist_pass_sequencer_addr_counter.sv
// Up-counter with synchronous load-zero that holds at a terminal value.
// Shared by the bin-clear sweep and both pixel passes.
module hist_addr_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt  = cnt_q;
  assign term = (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !term) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hist_pass_sequencer.sv
// Two-pass frame sequencer: clear bins, accumulate histogram,
// then stream the image again through the output mux.
module hist_pass_sequencer
  import hist_pkg::*;
#(
  parameter int NUM_PIXELS = 4096,
  parameter int ADDR_W     = 12,
  parameter int BINS       = 256,
  parameter int BIN_AW     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  hist_pass_sequencer_if.slave  bus
);

  localparam int CW =
    (ADDR_W > BIN_AW) ? ADDR_W : BIN_AW;
  localparam logic [CW-1:0] PIX_LAST =
    CW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] BIN_LAST =
    CW'(BINS - 1);

  state_e            state_q, state_d;
  logic              rd_q, rd_d;
  logic              p2_q, p2_d;
  logic [ADDR_W-1:0] wa_q, wa_d;

  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cnt_last;
  logic [CW-1:0] cnt;
  logic          term;
  logic          in_pass;

  hist_addr_counter #(.W(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last),
    .cnt  (cnt),
    .term (term)
  );

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_last = PIX_LAST;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (bus.start) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_en   = 1'b1;
        cnt_last = BIN_LAST;
        if (term) begin
          state_d = PASS1;
          cnt_clr = 1'b1;
        end
      end
      PASS1: begin
        cnt_en = 1'b1;
        if (term) begin
          state_d = DRAIN1;
          cnt_clr = 1'b1;
        end
      end
      DRAIN1: begin
        state_d = PASS2;
        cnt_clr = 1'b1;
      end
      PASS2: begin
        cnt_en = 1'b1;
        if (term) begin
          state_d = DRAIN2;
          cnt_clr = 1'b1;
        end
      end
      DRAIN2: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    // abort wins over start and over any pass progress
    if (bus.abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end
  end

  always_comb begin
    in_pass      = (state_q == PASS1) ||
                   (state_q == PASS2);
    bus.rd_en    = in_pass;
    bus.pix_addr = in_pass ? cnt[ADDR_W-1:0] : '0;
    bus.hist_clr = (state_q == CLEAR);
    bus.clr_addr = (state_q == CLEAR) ?
                   cnt[BIN_AW-1:0] : '0;
    bus.enable   = (state_q == PASS2) ||
                   (state_q == DRAIN2);
    bus.busy     = (state_q != IDLE);
    bus.done     = (state_q == DRAIN1);
    bus.reallydone = (state_q == DRAIN2);
    rd_d = in_pass && !bus.abort;
    p2_d = (state_q == PASS2);
    wa_d = bus.pix_addr;
    bus.acc_en  = rd_q && !p2_q;
    bus.we      = rd_q && p2_q;
    bus.wr_addr = wa_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      p2_q    <= 1'b0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      p2_q    <= p2_d;
      wa_q    <= wa_d;
    end
  end

endmodule

// File: tb/tb_hist_pass_sequencer.sv
// Scoreboard bench for hist_pass_sequencer with random frames,
// mid-frame starts, aborts and an asynchronous reset.
module tb_hist_pass_sequencer;

  localparam int NP = 8;
  localparam int AW = 3;
  localparam int NB = 4;
  localparam int BW = 2;
  localparam int FLEN = NB + 2 * NP + 2;

  localparam int EV_RD    = 0;
  localparam int EV_CLR   = 1;
  localparam int EV_ACC   = 2;
  localparam int EV_WE    = 3;
  localparam int EV_DONE  = 4;
  localparam int EV_RDONE = 5;

  typedef struct {
    int cyc;
    int kind;
    int addr;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hist_pass_sequencer_if #(.ADDR_W(AW), .BIN_AW(BW)) bus();

  hist_pass_sequencer #(
    .NUM_PIXELS (NP),
    .ADDR_W     (AW),
    .BINS       (NB),
    .BIN_AW     (BW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc = 0;
  ev_t  exp_q[$];
  int   busy_lo = 1, busy_hi = 0;
  int   en_lo = 1, en_hi = 0;
  int   checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected event stream of one frame whose start is sampled
  // at the end of cycle c; offset o counts cycles after that.
  function automatic void model_start(int c);
    for (int o = 1; o <= FLEN; o++) begin
      int t;
      t = c + o;
      if (o - NB - 1 >= 0 && o - NB - 1 < NP)
        exp_q.push_back('{t, EV_RD, o - NB - 1});
      if (o - NB - NP - 2 >= 0 && o - NB - NP - 2 < NP)
        exp_q.push_back('{t, EV_RD, o - NB - NP - 2});
      if (o <= NB)
        exp_q.push_back('{t, EV_CLR, o - 1});
      if (o - NB - 2 >= 0 && o - NB - 2 < NP)
        exp_q.push_back('{t, EV_ACC, 0});
      if (o - NB - NP - 3 >= 0 && o - NB - NP - 3 < NP)
        exp_q.push_back('{t, EV_WE, o - NB - NP - 3});
      if (o == NB + NP + 1)
        exp_q.push_back('{t, EV_DONE, 0});
      if (o == FLEN)
        exp_q.push_back('{t, EV_RDONE, 0});
    end
    busy_lo = c + 1;
    busy_hi = c + FLEN;
    en_lo   = c + NB + NP + 2;
    en_hi   = c + FLEN;
  endfunction

  // Nothing is expected after cycle c any more.
  function automatic void model_cut(int c);
    while (exp_q.size() > 0 && exp_q[$].cyc > c)
      void'(exp_q.pop_back());
    if (busy_hi > c) busy_hi = c;
    if (en_hi > c) en_hi = c;
  endfunction

  function automatic bit all_zero();
    return !(bus.rd_en || bus.hist_clr || bus.acc_en ||
             bus.we || bus.enable || bus.busy ||
             bus.done || bus.reallydone) &&
           bus.pix_addr == '0 && bus.clr_addr == '0 &&
           bus.wr_addr == '0;
  endfunction

  always @(negedge clk) begin
    ev_t ob[$];
    bit  exp_b;
    if (!rst) begin
      ob.delete();
      if (bus.rd_en)
        ob.push_back('{cyc, EV_RD, int'(bus.pix_addr)});
      if (bus.hist_clr)
        ob.push_back('{cyc, EV_CLR, int'(bus.clr_addr)});
      if (bus.acc_en) ob.push_back('{cyc, EV_ACC, 0});
      if (bus.we)
        ob.push_back('{cyc, EV_WE, int'(bus.wr_addr)});
      if (bus.done) ob.push_back('{cyc, EV_DONE, 0});
      if (bus.reallydone) ob.push_back('{cyc, EV_RDONE, 0});

      checks++;
      if ($countones({bus.hist_clr, bus.acc_en, bus.we}) > 1 ||
          (bus.done && bus.reallydone)) begin
        errors++;
        $display("FAIL excl @%0d: clr=%b acc=%b we=%b d=%b rd=%b",
                 cyc, bus.hist_clr, bus.acc_en, bus.we,
                 bus.done, bus.reallydone);
      end

      exp_b = (cyc >= busy_lo && cyc <= busy_hi);
      checks++;
      if (bus.busy !== exp_b) begin
        errors++;
        $display("FAIL busy @%0d: got %b exp %b",
                 cyc, bus.busy, exp_b);
      end

      exp_b = (cyc >= en_lo && cyc <= en_hi);
      checks++;
      if (bus.enable !== exp_b) begin
        errors++;
        $display("FAIL enable @%0d: got %b exp %b",
                 cyc, bus.enable, exp_b);
      end

      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed @%0d: exp c%0d k%0d a%0d",
                 cyc, exp_q[0].cyc, exp_q[0].kind, exp_q[0].addr);
        void'(exp_q.pop_front());
      end

      foreach (ob[i]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra @%0d: got k%0d a%0d exp none",
                   cyc, ob[i].kind, ob[i].addr);
        end else if (exp_q[0] != ob[i]) begin
          errors++;
          $display("FAIL event @%0d: got c%0d k%0d a%0d exp c%0d k%0d a%0d",
                   cyc, ob[i].cyc, ob[i].kind, ob[i].addr,
                   exp_q[0].cyc, exp_q[0].kind, exp_q[0].addr);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit s, bit a);
    bus.start = s;
    bus.abort = a;
    if (a) model_cut(cyc);
    else if (s && cyc > busy_hi) model_start(cyc);
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc <= busy_hi && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: cyc %0d exp end %0d",
               cyc, busy_hi);
    end
    tick();
  endtask

  task automatic check(string nm, bit ok, int got, int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d exp %0d", nm, got, expv);
    end
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", all_zero(), int'(bus.busy), 0);
    rst = 1'b0;
    tick();

    // nominal frame
    issue(1'b1, 1'b0);
    wait_idle();

    // start inside PASS2 is dropped
    issue(1'b1, 1'b0);
    repeat (15) tick();
    check("in_pass2", bus.enable === 1'b1, int'(bus.enable), 1);
    issue(1'b1, 1'b0);
    wait_idle();
    issue(1'b1, 1'b0);
    wait_idle();

    // abort at pixel 3 of the first pass
    issue(1'b1, 1'b0);
    repeat (7) tick();
    check("abort_addr", bus.pix_addr == 3'd3,
          int'(bus.pix_addr), 3);
    issue(1'b0, 1'b1);
    check("abort_busy", bus.busy === 1'b0, int'(bus.busy), 0);
    check("abort_acc", bus.acc_en === 1'b0,
          int'(bus.acc_en), 0);
    wait_idle();

    // start and abort together while idle
    issue(1'b1, 1'b1);
    check("start_abort", bus.busy === 1'b0, int'(bus.busy), 0);
    tick();

    // asynchronous reset in the middle of the first pass
    issue(1'b1, 1'b0);
    repeat (7) tick();
    model_cut(cyc - 1);
    rst = 1'b1;
    #1;
    check("reset_mid", all_zero(), int'(bus.busy), 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset_idle", bus.busy === 1'b0, int'(bus.busy), 0);

    repeat (30) begin
      int mode, off;
      repeat ($urandom_range(0, 3)) tick();
      issue(1'b1, 1'b0);
      mode = $urandom_range(0, 3);
      off  = $urandom_range(0, FLEN);
      if (mode != 0) begin
        repeat (off) tick();
        if (mode == 1) issue(1'b1, 1'b0);
        else if (mode == 2) issue(1'b0, 1'b1);
        else issue(1'b1, 1'b1);
      end
      wait_idle();
    end

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
